dpram_drain: RTL
================

Name: dpram_drain

Overview:
- Downstream consumer of the waveform buffer reader's DPRAM. It is the stage the reader hands off to when it asserts dpram_run.
- On dpram_run it latches dpram_len, holds dpram_busy, and reads the 1024x32 DPRAM.
- It streams the contents as 16-bit halfwords over a valid/ready interface to the readout link, then pulses dpram_done so the reader can reuse the buffer.

Parameters:
- ADDR_W, 10, DPRAM address width in 32-bit words.
- MAX_LEN, 2048, largest legal dpram_len in halfwords; must be 2*2^ADDR_W or less.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dpram_run  in  1  one-cycle start pulse from the reader
- dpram_len  in  16  transfer length in 16-bit halfwords; sampled on dpram_run
- dpram_rd_addr  out  ADDR_W  DPRAM read address
- dpram_rd_data  in  32  DPRAM read data, valid 1 cycle after address (registered RAM)
- dpram_busy  out  1  high from the cycle after dpram_run until done
- dpram_done  out  1  one-cycle pulse at end of transfer
- len_err  out  1  one-cycle pulse, coincident with dpram_done, for illegal length
- out_data  out  16  halfword stream
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_last  out  1  marks the final halfword of a transfer

Behaviour:
- Reset values: dpram_busy=0, dpram_done=0, len_err=0, out_valid=0, out_last=0, out_data=0, dpram_rd_addr=0. FSM is in IDLE.
- rst in any state aborts the transfer within 1 cycle. No dpram_done is issued for the aborted transfer.
- States: IDLE, FETCH, WAIT, SEND_LO, SEND_HI, FINISH.
- IDLE:
  - On dpram_run, latch len = dpram_len and set the halfword counter to 0.
  - If len==0 or len>MAX_LEN, go to FINISH with the error flag set.
  - Otherwise go to FETCH with dpram_rd_addr=0. dpram_busy rises on the next edge.
- FETCH: drive dpram_rd_addr = word index, then go to WAIT.
- WAIT:
  - Capture dpram_rd_data into a 32-bit holding register.
  - Assert out_valid with out_data = hold[15:0] and go to SEND_LO.
  - First out_valid appears 3 cycles after dpram_run.
- SEND_LO: on out_valid && out_ready, increment the halfword counter.
  - If the counter now equals len, go to FINISH. This covers odd len: the high half of the final word is dropped.
  - Otherwise present hold[31:16] and go to SEND_HI.
- SEND_HI: on accept, increment the counter.
  - If it equals len, go to FINISH.
  - Otherwise increment the word index and go to FETCH. out_valid is low during FETCH and WAIT.
- Stream rule: once out_valid is high, out_data and out_last stay stable until accepted. out_valid never drops without a handshake.
- out_last is high exactly when the presented halfword is halfword index len-1.
- FINISH:
  - dpram_done=1 for one cycle; len_err=1 in the same cycle if the error flag is set.
  - dpram_busy falls on the same edge. Return to IDLE.
  - On the error path no stream data is produced and dpram_done occurs 2 cycles after dpram_run.
- dpram_run while busy is ignored: no relatch and no effect on the current transfer.
- dpram_run in the same cycle as dpram_done is also ignored. The reader must wait for busy=0.
- Throughput with out_ready held at 1: 2 halfwords per 4 cycles.
- Cycle count for an accepted even len, without the optional feature: 2*len + 3 cycles from dpram_run to dpram_done.
- Counters are 16-bit with no wrap. len is bounded by MAX_LEN, so the word index never exceeds 2^ADDR_W-1.

Optional Feature:
- Macro DPRAM_DRAIN_CRC_EN.
- When defined, a CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB first) is computed over every accepted halfword. It is appended as one extra halfword in a SEND_CRC state before FINISH.
- out_last moves to the CRC halfword, and transfer length on the stream becomes len+1.
- On the error path no CRC is sent.
- When undefined, the CRC logic and state are absent and the behaviour is exactly as above.

Test Plan:
- DPRAM preloaded word k = {16'hA000+k, 16'h5000+k}; dpram_len=6, out_ready=1.
  - Stream is 5000,A000,5001,A001,5002,A002; out_last only on A002.
  - dpram_done at cycle 15 after run; busy high cycles 1..15.
- Same preload, dpram_len=5: stream ends at 5002 with out_last set; A002 is never output; single dpram_done.
- dpram_len=0, then dpram_len=2049: each gives len_err and dpram_done together 2 cycles after run, with out_valid never high.
- dpram_len=4 with out_ready low for 7 cycles on the second halfword: out_data holds 0xA000 stable throughout; all 4 halfwords delivered in order.
- Second dpram_run pulse mid-transfer (len=1024), then rst asserted at halfword 300:
  - The second run is ignored.
  - After rst, busy=0, out_valid=0, and no done pulse.
  - A new run with len=2 then completes normally.
- With DPRAM_DRAIN_CRC_EN, len=2, data {0x0000,0x1234}: stream is 1234,0000,CRC; the CRC matches the reference model; out_last is on the CRC word only.

Source files
------------

// File: rtl/dpram_drain.sv
// dpram_drain: drains a latched-length DPRAM buffer as a halfword stream; DPRAM_DRAIN_CRC_EN appends a CRC-16/CCITT halfword
module dpram_drain #(
  parameter int ADDR_W = 10,
  parameter int MAX_LEN = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dpram_run,
  input  logic [15:0]       dpram_len,
  output logic [ADDR_W-1:0] dpram_rd_addr,
  input  logic [31:0]       dpram_rd_data,
  output logic              dpram_busy,
  output logic              dpram_done,
  output logic              len_err,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
`ifdef DPRAM_DRAIN_CRC_EN
  localparam bit CRC_EN = 1'b1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND_LO, SEND_HI, FINISH, SEND_CRC} state_t;
  localparam state_t TAIL = SEND_CRC;
`else
  localparam bit CRC_EN = 1'b0;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND_LO, SEND_HI, FINISH} state_t;
  localparam state_t TAIL = FINISH;
`endif
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  state_t state, state_n;
  logic [15:0] len, cnt, cnt_inc, hold_hi, tail_data;
  logic [ADDR_W-1:0] widx;
  logic err, drain, acc, start, bad, fin, sending;
  assign acc = out_valid && out_ready;
  assign start = state == IDLE && dpram_run && !dpram_busy;
  assign bad = dpram_len == 16'd0 || dpram_len > MAX_L;
  assign cnt_inc = cnt + 16'd1;
  assign fin = cnt_inc == len;
  assign sending = state == SEND_LO || state == SEND_HI;
  assign dpram_rd_addr = widx;
`ifdef DPRAM_DRAIN_CRC_EN
  logic [15:0] crc, crc_n;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = (r[15] ^ d[i]) ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
  assign crc_n = crc_upd(crc, out_data);
  assign tail_data = crc_n;
  // running CRC over every accepted data halfword
  always_ff @(posedge clk) begin
    if (rst || start) crc <= 16'hFFFF;
    else if (sending && acc) crc <= crc_n;
  end
`else
  assign tail_data = out_data;
`endif
  // next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? (bad ? FINISH : FETCH) : IDLE;
      FETCH:    state_n = WAIT;
      WAIT:     state_n = SEND_LO;
      SEND_LO:  state_n = acc ? (fin ? TAIL : SEND_HI) : SEND_LO;
      SEND_HI:  state_n = acc ? (fin ? TAIL : FETCH) : SEND_HI;
`ifdef DPRAM_DRAIN_CRC_EN
      SEND_CRC: state_n = acc ? FINISH : SEND_CRC;
`endif
      FINISH:   state_n = (err || drain) ? IDLE : FINISH;
      default:  state_n = IDLE;
    endcase
  end
  // state register and datapath; normal transfers spend one settle cycle in FINISH before done
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= 16'd0;
      cnt        <= 16'd0;
      widx       <= '0;
      hold_hi    <= 16'd0;
      err        <= 1'b0;
      drain      <= 1'b0;
      dpram_busy <= 1'b0;
      dpram_done <= 1'b0;
      len_err    <= 1'b0;
      out_data   <= 16'd0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state      <= state_n;
      dpram_done <= 1'b0;
      len_err    <= 1'b0;
      if (dpram_done) dpram_busy <= 1'b0;
      if (start) begin
        len        <= dpram_len;
        cnt        <= 16'd0;
        widx       <= '0;
        err        <= bad;
        drain      <= 1'b0;
        dpram_busy <= 1'b1;
      end
      if (state == WAIT) begin
        hold_hi   <= dpram_rd_data[31:16];
        out_data  <= dpram_rd_data[15:0];
        out_valid <= 1'b1;
        out_last  <= !CRC_EN && cnt == len - 16'd1;
      end
      if (sending && acc) begin
        cnt <= cnt_inc;
        if (fin) begin
          out_data  <= tail_data;
          out_valid <= CRC_EN;
          out_last  <= CRC_EN;
        end else if (state == SEND_LO) begin
          out_data <= hold_hi;
          out_last <= !CRC_EN && cnt_inc == len - 16'd1;
        end else begin
          out_valid <= 1'b0;
          widx      <= widx + ADDR_W'(1);
        end
      end
`ifdef DPRAM_DRAIN_CRC_EN
      if (state == SEND_CRC && acc) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
`endif
      if (state == FINISH) begin
        if (err || drain) begin
          dpram_done <= 1'b1;
          len_err    <= err;
        end else drain <= 1'b1;
      end
    end
  end
endmodule
